// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start(0), DATA_W data bits LSB-first, parity bit, stop(1); checks parity and stop bit.
// Latency: data_valid pulses one clk after the cycle carrying the stop-bit strobe.
// No backpressure: bits arrive as rx_valid strobes and the consumer must take the one-cycle data_valid pulse.
module serial_parity_rx #(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    input  logic              rx_valid,
    input  logic              rx_bit,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shift_reg;
    logic [CNT_W-1:0]  cnt;
    logic              acc;
    logic              perr_q;

    // Frame FSM plus the held output word/flags; only rx_valid strobes move it, abort overrides them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            shift_reg  <= '0;
            cnt        <= '0;
            acc        <= 1'b0;
            perr_q     <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            // The completion pulse lasts exactly one cycle.
            data_valid <= 1'b0;
            if (abort) begin
                // Drop the frame; the last delivered word and its flags stay visible.
                state <= S_IDLE;
                cnt   <= '0;
                acc   <= 1'b0;
            end else if (rx_valid) begin
                case (state)
                    S_IDLE: begin
                        // A 1 on an idle line is just the line resting high.
                        if (!rx_bit) begin
                            state <= S_DATA;
                            cnt   <= '0;
                            acc   <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        // LSB arrives first, so shifting in at the MSB leaves it at bit 0 at the end.
                        shift_reg <= {rx_bit, shift_reg[DATA_W-1:1]};
                        acc       <= acc ^ rx_bit;
                        if (cnt == LAST_BIT) begin
                            state <= S_PARITY;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    S_PARITY: begin
                        perr_q <= acc ^ rx_bit ^ ODD_PARITY;
                        state  <= S_STOP;
                    end
                    S_STOP: begin
                        // A bad stop bit is flagged but the word is still delivered.
                        data_out   <= shift_reg;
                        parity_err <= perr_q;
                        frame_err  <= ~rx_bit;
                        data_valid <= 1'b1;
                        state      <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Busy whenever a frame is in progress.
    always_comb begin
        busy = (state != S_IDLE);
    end

endmodule
